data_memory_param: RTL and testbench

- Parametrised successor to the single-port word data memory of the KGPMini RISC datapath.
- Generalises data width and depth, and adds per-byte write enables.
- Read latency is configurable: a pipeline of 1..4 cycles, with a valid strobe.
- Also adds selectable read-during-write semantics, out-of-range detection, and an optional post-reset zero-clear sweep behind a ready handshake.
- Sits between the execute/memory stage and the writeback mux.

---
 rtl/dm_pkg.sv | 28 ++
 rtl/data_memory_param_if.sv | 27 ++
 rtl/dm_read_pipe.sv | 48 ++++
 rtl/data_memory_param.sv | 132 +++++++++++++
 tb/tb_data_memory_param.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants, state type and parameter checks for data_memory_param
package dm_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dm_state_e;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic bit width_ok(input int data_width);
    return (data_width > 0) && ((data_width % 8) == 0);
  endfunction

  function automatic bit latency_ok(input int read_latency);
    return (read_latency >= 1) && (read_latency <= 4);
  endfunction

  function automatic bit depth_ok(input int depth, input int addr_width);
    return (depth >= 1) && ((addr_width >= 31) || (depth <= (1 << addr_width)));
  endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// rtl/data_memory_param_if.sv - request/response bundle between memory stage and data memory
interface data_memory_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic [ADDR_WIDTH-1:0]   address_in;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic                    MemWrite;
  logic                    MemRead;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    rd_valid;
  logic                    addr_err;

  modport master (
    output address_in, write_data, byte_en, MemWrite, MemRead,
    input  ready, data_out, rd_valid, addr_err
  );

  modport slave (
    input  address_in, write_data, byte_en, MemWrite, MemRead,
    output ready, data_out, rd_valid, addr_err
  );

endinterface

// File: rtl/dm_read_pipe.sv
// rtl/dm_read_pipe.sv - LATENCY-deep {valid, err, data} shift register for read responses
module dm_read_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [LATENCY-1:0]    valid_q;
  logic [LATENCY-1:0]    err_q;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  // Data stages only load on a valid beat so the last read value is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= err_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int s = 1; s < LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        err_q[s]   <= err_q[s-1];
        if (valid_q[s-1]) begin
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign err_o   = err_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/data_memory_param.sv
// rtl/data_memory_param.sv - parametrised byte-enabled data memory with pipelined reads and zero-clear sweep
module data_memory_param
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter int INIT_CLEAR   = 1
) (
  input logic                clk,
  input logic                rst_n,
  data_memory_param_if.slave bus
);

  localparam int                  BE_W     = be_width(DATA_WIDTH);
  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
  localparam dm_state_e           RST_ST   = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  if (!width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("DATA_WIDTH must be a positive multiple of 8");
  end
  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (!depth_ok(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must be in 1..2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  dm_state_e             state_q, state_d;
  logic [IDX_W-1:0]      sweep_q, sweep_d;
  logic                  ready_q, ready_d;
  logic                  werr_q, werr_d;

  logic                  rd_acc, wr_acc, in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] old_word, merged_word, rd_data;
  logic                  pipe_err;

  assign rd_acc   = ready_q & bus.MemRead;
  assign wr_acc   = ready_q & bus.MemWrite;
  // Compare one bit wider so DEPTH == 2**ADDR_WIDTH never flags an error.
  assign in_range = ({1'b0, bus.address_in} < DEPTH_W);
  assign idx      = bus.address_in[IDX_W-1:0];
  assign old_word = mem[idx];

  always_comb begin
    merged_word = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (bus.byte_en[b]) begin
        merged_word[b*8 +: 8] = bus.write_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_data = old_word;
    if (!in_range) begin
      rd_data = '0;
    end else if ((RDW_MODE == RDW_NEW) && wr_acc) begin
      rd_data = merged_word;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    ready_d = (state_d == ST_RUN);
    // A paired read carries the error on its response, so only lone writes pulse here.
    werr_d  = wr_acc & ~rd_acc & ~in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_ST;
      sweep_q <= '0;
      ready_q <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
      werr_q  <= werr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[sweep_q] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.byte_en[b]) begin
          mem[idx][b*8 +: 8] <= bus.write_data[b*8 +: 8];
        end
      end
    end
  end

  dm_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (rd_acc),
    .err_i   (rd_acc & ~in_range),
    .data_i  (rd_data),
    .valid_o (bus.rd_valid),
    .err_o   (pipe_err),
    .data_o  (bus.data_out)
  );

  assign bus.ready    = ready_q;
  assign bus.addr_err = pipe_err | werr_q;

endmodule

// File: tb/tb_data_memory_param.sv
// tb/tb_data_memory_param.sv - directed self-checking bench for data_memory_param
module tb_data_memory_param;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_memory_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) ifa ();
  data_memory_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) ifb ();
  data_memory_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) ifc ();

  data_memory_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(16),
    .READ_LATENCY(3), .RDW_MODE(0), .INIT_CLEAR(1)
  ) u_a (.clk(clk), .rst_n(rst_a), .bus(ifa));

  data_memory_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000),
    .READ_LATENCY(1), .RDW_MODE(1), .INIT_CLEAR(0)
  ) u_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

  data_memory_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(16),
    .READ_LATENCY(2), .RDW_MODE(0), .INIT_CLEAR(1)
  ) u_c (.clk(clk), .rst_n(rst_c), .bus(ifc));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ev;
    logic        ee;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic rd, input logic wr, input logic [9:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    ifa.MemRead = rd; ifa.MemWrite = wr; ifa.address_in = ad;
    ifa.write_data = wd; ifa.byte_en = be;
  endtask

  task automatic set_b(input logic rd, input logic wr, input logic [9:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    ifb.MemRead = rd; ifb.MemWrite = wr; ifb.address_in = ad;
    ifb.write_data = wd; ifb.byte_en = be;
  endtask

  task automatic set_c(input logic rd, input logic wr, input logic [9:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    ifc.MemRead = rd; ifc.MemWrite = wr; ifc.address_in = ad;
    ifc.write_data = wd; ifc.byte_en = be;
  endtask

  initial begin
    int ra, rb, rc, cnt, zbad, first_k;

    n_tests = 0;
    n_fail  = 0;

    //                rd    wr    addr      wdata         be    ev    ee    ed
    vecs[0]  = '{1'b0, 1'b1, 10'd986,  32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 10'd7,    32'h00000000, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 10'd7,    32'h00000055, 4'hF, 1'b1, 1'b0, 32'h55};
    vecs[3]  = '{1'b1, 1'b0, 10'd7,    32'h0,        4'h0, 1'b1, 1'b0, 32'h55};
    vecs[4]  = '{1'b0, 1'b1, 10'd1010, 32'h00001234, 4'hF, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 10'd1010, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 10'd986,  32'h0,        4'h0, 1'b1, 1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b1, 10'd2,    32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 10'd2,    32'hAABBCCDD, 4'h5, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 10'd2,    32'h0,        4'h0, 1'b1, 1'b0, 32'h11BB33DD};
    vecs[10] = '{1'b0, 1'b1, 10'd2,    32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 10'd2,    32'h0,        4'h0, 1'b1, 1'b0, 32'h11BB33DD};
    vecs[12] = '{1'b1, 1'b1, 10'd1010, 32'h0000BEEF, 4'hF, 1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 10'd0,    32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 10'd999,  32'h000000A5, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 10'd999,  32'h0,        4'h0, 1'b1, 1'b0, 32'hA5};
    vecs[16] = '{1'b1, 1'b0, 10'd1000, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
    set_c(1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();

    check("rst_ready_a",    {31'b0, ifa.ready},    32'd0);
    check("rst_valid_a",    {31'b0, ifa.rd_valid}, 32'd0);
    check("rst_err_a",      {31'b0, ifa.addr_err}, 32'd0);
    check("rst_data_a",     ifa.data_out,          32'd0);
    check("rst_ready_b",    {31'b0, ifb.ready},    32'd0);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ra = 0; rb = 0; rc = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ifa.ready && ra == 0) ra = n;
      if (ifb.ready && rb == 0) rb = n;
      if (ifc.ready && rc == 0) rc = n;
    end
    check("ready_rise_a", ra, 32'd16);
    check("ready_rise_b", rb, 32'd1);
    check("ready_rise_c", rc, 32'd16);

    // Table-driven vectors on the single-cycle, new-data instance.
    for (int i = 0; i < 17; i++) begin
      set_b(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      tick();
      check($sformatf("vec%0d_valid", i), {31'b0, ifb.rd_valid}, {31'b0, vecs[i].ev});
      check($sformatf("vec%0d_err", i),   {31'b0, ifb.addr_err}, {31'b0, vecs[i].ee});
      if (vecs[i].ev) check($sformatf("vec%0d_data", i), ifb.data_out, vecs[i].ed);
    end
    set_b(1'b0, 1'b0, '0, '0, '0);

    // Sweep result: pipelined reads of all 16 words come back zero.
    cnt = 0; zbad = 0; first_k = -1;
    for (int k = 0; k < 19; k++) begin
      if (k < 16) set_a(1'b1, 1'b0, 10'(k), '0, '0);
      else        set_a(1'b0, 1'b0, '0, '0, '0);
      tick();
      if (ifa.rd_valid) begin
        cnt++;
        if (first_k < 0) first_k = k;
        if (ifa.data_out !== 32'd0) zbad++;
      end
    end
    check("sweep_reads", cnt, 32'd16);
    check("sweep_nonzero", zbad, 32'd0);
    check("sweep_first_valid", first_k, 32'd2);

    // Latency 3: write at k=0, read at k=1, response only after edge k=3.
    for (int k = 0; k < 11; k++) begin
      case (k)
        0:       set_a(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
        1:       set_a(1'b1, 1'b0, 10'd5, '0, '0);
        default: set_a(1'b0, 1'b0, '0, '0, '0);
      endcase
      tick();
      check($sformatf("lat3_valid_k%0d", k), {31'b0, ifa.rd_valid}, {31'b0, (k == 3)});
      if (k == 3) check("lat3_data", ifa.data_out, 32'hDEADBEEF);
      if (k == 8) check("lat3_hold", ifa.data_out, 32'hDEADBEEF);
    end

    // Old-data read-during-write, then a following read sees the new word.
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       set_a(1'b0, 1'b1, 10'd7, 32'h0, 4'hF);
        1:       set_a(1'b1, 1'b1, 10'd7, 32'h55, 4'hF);
        2:       set_a(1'b1, 1'b0, 10'd7, '0, '0);
        default: set_a(1'b0, 1'b0, '0, '0, '0);
      endcase
      tick();
      check($sformatf("rdw_old_valid_k%0d", k), {31'b0, ifa.rd_valid}, {31'b0, (k == 3 || k == 4)});
      if (k == 3) check("rdw_old_data", ifa.data_out, 32'h0);
      if (k == 4) check("rdw_follow_data", ifa.data_out, 32'h55);
    end

    // Out-of-range read through the 3-deep pipe.
    for (int k = 0; k < 4; k++) begin
      if (k == 0) set_a(1'b1, 1'b0, 10'd20, '0, '0);
      else        set_a(1'b0, 1'b0, '0, '0, '0);
      tick();
      check($sformatf("oor3_err_k%0d", k), {31'b0, ifa.addr_err}, {31'b0, (k == 2)});
      if (k == 2) check("oor3_data", ifa.data_out, 32'h0);
    end

    // Reset with reads in flight, then verify the sweep reruns from 0.
    set_c(1'b0, 1'b1, 10'd3, 32'h77, 4'hF);
    tick();
    set_c(1'b1, 1'b0, 10'd3, '0, '0);
    tick();
    set_c(1'b1, 1'b0, 10'd4, '0, '0);
    tick();
    @(negedge clk);
    rst_c = 1'b0;
    set_c(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("midrst_valid", {31'b0, ifc.rd_valid}, 32'd0);
    check("midrst_data",  ifc.data_out,          32'd0);
    check("midrst_ready", {31'b0, ifc.ready},    32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("midrst_hold_valid_k%0d", k), {31'b0, ifc.rd_valid}, 32'd0);
    end
    rst_c = 1'b1;
    rc = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ifc.ready && rc == 0) rc = n;
    end
    check("resweep_ready_rise", rc, 32'd16);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) set_c(1'b1, 1'b0, 10'd3, '0, '0);
      else        set_c(1'b0, 1'b0, '0, '0, '0);
      tick();
      if (ifc.rd_valid) begin
        cnt++;
        check("resweep_word3", ifc.data_out, 32'h0);
      end
    end
    check("resweep_read_count", cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
